// File: rtl/frontend_mode_ctrl_if.sv
// Measurement and reconfiguration bundle between the TVP7002 frontend and the mode-lock sequencer.
// Optional FRONTEND_HSYNCW_CHECK_EN adds the locked hsync width output.
interface frontend_mode_ctrl_if;
    logic        frame_stb_i;
    logic        sync_active_i;
    logic [10:0] vtotal_i;
    logic [19:0] pcnt_frame_i;
    logic        interlace_i;
    logic [7:0]  hsync_width_i;
    logic        cfg_ack_i;
    logic        cfg_req_o;
    logic        mode_valid_o;
    logic        mode_change_o;
    logic [10:0] mode_vtotal_o;
    logic [19:0] mode_pcnt_frame_o;
    logic        mode_interlace_o;
    logic [1:0]  state_o;
`ifdef FRONTEND_HSYNCW_CHECK_EN
    logic [7:0]  mode_hsync_width_o;
`endif

    modport master (
        output frame_stb_i, sync_active_i, vtotal_i, pcnt_frame_i,
        output interlace_i, hsync_width_i, cfg_ack_i,
        input  cfg_req_o, mode_valid_o, mode_change_o, mode_vtotal_o,
`ifdef FRONTEND_HSYNCW_CHECK_EN
        input  mode_hsync_width_o,
`endif
        input  mode_pcnt_frame_o, mode_interlace_o, state_o
    );

    modport slave (
        input  frame_stb_i, sync_active_i, vtotal_i, pcnt_frame_i,
        input  interlace_i, hsync_width_i, cfg_ack_i,
        output cfg_req_o, mode_valid_o, mode_change_o, mode_vtotal_o,
`ifdef FRONTEND_HSYNCW_CHECK_EN
        output mode_hsync_width_o,
`endif
        output mode_pcnt_frame_o, mode_interlace_o, state_o
    );
endinterface

// File: rtl/frontend_mode_ctrl.sv
// Mode-lock sequencer: qualifies stable frontend modes and requests timing reconfiguration.
// Optional FRONTEND_HSYNCW_CHECK_EN also compares hsync width when matching modes.
module frontend_mode_ctrl #(
    parameter int STABLE_FRAMES  = 3,
    parameter int LOSS_FRAMES    = 2,
    parameter int PCNT_TOL       = 64,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input logic                 CLK_MEAS_i,
    input logic                 reset,
    frontend_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        NOSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        CFG_REQ = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    typedef struct packed {
        logic [10:0] vtotal;
        logic [19:0] pcnt;
        logic        il;
`ifdef FRONTEND_HSYNCW_CHECK_EN
        logic [7:0]  hsw;
`endif
    } meas_t;

    localparam logic [21:0] TO_LIM   = 22'(TIMEOUT_CYCLES);
    localparam logic [20:0] TOL      = 21'(PCNT_TOL);
    localparam logic [3:0]  STB_LAST = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0]  LOSS_LIM = 4'(LOSS_FRAMES);

    function automatic logic match(input meas_t a, input meas_t b);
        logic [20:0] d;
        logic        ok;
        d = {1'b0, a.pcnt} - {1'b0, b.pcnt};
        if (d[20])
            d = -d;
        ok = (a.vtotal == b.vtotal) && (a.il == b.il) && (d <= TOL)
          && (a.vtotal != '0) && (b.vtotal != '0)
          && (a.pcnt != '0) && (b.pcnt != '0);
`ifdef FRONTEND_HSYNCW_CHECK_EN
        begin
            logic [8:0] h;
            h = {1'b0, a.hsw} - {1'b0, b.hsw};
            if (h[8])
                h = -h;
            ok = ok && (h <= 9'd2);
        end
`endif
        return ok;
    endfunction

    state_t      state;
    meas_t       cand;
    meas_t       lk;
    meas_t       cur;
    logic        cand_valid;
    logic        lk_valid;
    logic [3:0]  stable_ctr;
    logic [3:0]  loss_ctr;
    logic [21:0] to_ctr;
    logic        cfg_req;
    logic        mode_valid;
    logic        mode_change;

    logic        loss_ev;
    logic        m_cand;
    logic        m_lk;
    logic [3:0]  stb_nxt;
    logic [3:0]  loss_nxt;

    always_comb begin
        cur        = '0;
        cur.vtotal = bus.vtotal_i;
        cur.pcnt   = bus.pcnt_frame_i;
        cur.il     = bus.interlace_i;
`ifdef FRONTEND_HSYNCW_CHECK_EN
        cur.hsw    = bus.hsync_width_i;
`endif
    end

`ifndef FRONTEND_HSYNCW_CHECK_EN
    logic unused_hsw;
    assign unused_hsw = ^bus.hsync_width_i;
`endif

    assign loss_ev = (to_ctr >= TO_LIM) || !bus.sync_active_i;
    assign m_cand  = cand_valid && match(cur, cand);
    assign m_lk    = lk_valid && match(cur, lk);

    always_comb begin
        stb_nxt  = '0;
        loss_nxt = loss_ctr;
        if (m_cand)
            stb_nxt = (stable_ctr == 4'hf) ? stable_ctr : stable_ctr + 4'd1;
        if (loss_ctr != 4'hf)
            loss_nxt = loss_ctr + 4'd1;
    end

    // Watchdog runs in every state; a strobe is the only thing that clears it.
    always_ff @(posedge CLK_MEAS_i or posedge reset) begin
        if (reset)
            to_ctr <= '0;
        else if (bus.frame_stb_i)
            to_ctr <= '0;
        else if (to_ctr != '1)
            to_ctr <= to_ctr + 22'd1;
    end

    always_ff @(posedge CLK_MEAS_i or posedge reset) begin
        if (reset) begin
            state       <= NOSYNC;
            cand        <= '0;
            lk          <= '0;
            cand_valid  <= 1'b0;
            lk_valid    <= 1'b0;
            stable_ctr  <= '0;
            loss_ctr    <= '0;
            cfg_req     <= 1'b0;
            mode_valid  <= 1'b0;
            mode_change <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            if (loss_ev) begin
                state      <= NOSYNC;
                cfg_req    <= 1'b0;
                mode_valid <= 1'b0;
                stable_ctr <= '0;
                loss_ctr   <= '0;
            end else begin
                unique case (state)
                    NOSYNC: begin
                        state      <= ACQUIRE;
                        stable_ctr <= '0;
                        cand_valid <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (bus.frame_stb_i) begin
                            cand       <= cur;
                            cand_valid <= 1'b1;
                            stable_ctr <= stb_nxt;
                            if (stb_nxt >= STB_LAST) begin
                                // Same mode seen again: skip reconfiguration.
                                if (m_lk) begin
                                    state      <= LOCKED;
                                    mode_valid <= 1'b1;
                                    loss_ctr   <= '0;
                                end else begin
                                    lk          <= cur;
                                    lk_valid    <= 1'b1;
                                    state       <= CFG_REQ;
                                    cfg_req     <= 1'b1;
                                    mode_change <= 1'b1;
                                end
                            end
                        end
                    end
                    CFG_REQ: begin
                        if (bus.cfg_ack_i) begin
                            cfg_req    <= 1'b0;
                            mode_valid <= 1'b1;
                            state      <= LOCKED;
                            loss_ctr   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (bus.frame_stb_i) begin
                            if (m_lk) begin
                                loss_ctr <= '0;
                            end else if (loss_nxt >= LOSS_LIM) begin
                                mode_valid <= 1'b0;
                                state      <= ACQUIRE;
                                stable_ctr <= '0;
                                loss_ctr   <= '0;
                                cand       <= cur;
                                cand_valid <= 1'b1;
                            end else begin
                                loss_ctr <= loss_nxt;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.state_o           = state;
    assign bus.cfg_req_o         = cfg_req;
    assign bus.mode_valid_o      = mode_valid;
    assign bus.mode_change_o     = mode_change;
    assign bus.mode_vtotal_o     = lk.vtotal;
    assign bus.mode_pcnt_frame_o = lk.pcnt;
    assign bus.mode_interlace_o  = lk.il;
`ifdef FRONTEND_HSYNCW_CHECK_EN
    assign bus.mode_hsync_width_o = lk.hsw;
`endif

endmodule
